// File: rtl/alu_issue_sched.sv
// Per-PE context sequencer / issue scheduler for the CGRA ALU: walks a loaded
// instruction store and issues only when the opcode's writeback slot is free.
module alu_issue_sched #(
  parameter int AWIDTH     = 8,
  parameter int MAC_LAT    = 3,
  parameter int ADDSUB_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Cfg_We,
  input  logic [AWIDTH-1:0] Cfg_Addr,
  input  logic [9:0]        Cfg_Data,
  input  logic              Start,
  input  logic [AWIDTH-1:0] Start_Addr,
  input  logic [AWIDTH-1:0] End_Addr,
  input  logic [15:0]       Iter_Num,
  input  logic              Stall,
  output logic [3:0]        Opcode,
  output logic [1:0]        Sel0,
  output logic [1:0]        Sel1,
  output logic [1:0]        Sel2,
  output logic              Issue_Valid,
  output logic              Result_Valid,
  output logic [3:0]        Result_Opcode,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [1:0]        Dbg_State,
  output logic [AWIDTH-1:0] Dbg_Pc
);

  localparam int DEPTH = 2**AWIDTH;

  // Issue_Valid and Result_Valid are single-cycle qualifiers with no back-pressure:
  // Opcode/Sel* are meaningful only while Issue_Valid=1, Result_Opcode only while
  // Result_Valid=1; the consumer must take the value in that cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [9:0]        mem [DEPTH];
  logic [AWIDTH-1:0] pc_q, start_q, end_q;
  logic [15:0]       iter_q;
  logic [MAC_LAT-1:0] resv_q, resv_d;
  logic [3:0]        tag_q [MAC_LAT];
  logic [3:0]        tag_d [MAC_LAT];

  logic [9:0] instr;
  logic [3:0] op;
  logic [3:0] lat;
  logic       reserved;
  logic       slot_free;
  logic       do_issue;
  logic       last_issue;
  logic       start_ok;

  assign instr     = mem[pc_q];
  assign op        = instr[3:0];
  assign reserved  = (op > 4'd8);
  assign start_ok  = (state_q == S_IDLE) && Start;
  assign Busy      = (state_q != S_IDLE);
  assign Dbg_State = state_q;
  assign Dbg_Pc    = pc_q;

  always_comb begin
    lat = 4'd0;
    unique case (op)
      4'h1, 4'h2:       lat = 4'(MAC_LAT);
      4'h3, 4'h4, 4'h5: lat = 4'(ADDSUB_LAT);
      4'h6, 4'h7, 4'h8: lat = 4'd1;
      default:          lat = 4'd0;
    endcase
  end

  // Slot k-1 after this cycle's shift is the writeback k cycles from this edge.
  always_comb begin
    resv_d    = resv_q >> 1;
    for (int k = 0; k < MAC_LAT - 1; k++) tag_d[k] = tag_q[k+1];
    tag_d[MAC_LAT-1] = 4'd0;
    slot_free = 1'b1;
    for (int k = 0; k < MAC_LAT; k++)
      if (lat == 4'(k + 1)) slot_free = !resv_d[k];
    do_issue = (state_q == S_RUN) && !Stall && slot_free;
    if (do_issue) begin
      for (int k = 0; k < MAC_LAT; k++) begin
        if (lat == 4'(k + 1)) begin
          resv_d[k] = 1'b1;
          tag_d[k]  = op;
        end
      end
    end
  end

  assign last_issue = do_issue && (pc_q == end_q) && (iter_q == 16'd1);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (Start) state_d = S_RUN;
      S_RUN:   if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (resv_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The store keeps its contents across Reset; it is only reloaded in IDLE.
  always_ff @(posedge Clk) begin
    if (Cfg_We && (state_q == S_IDLE)) mem[Cfg_Addr] <= Cfg_Data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q          <= '0;
      start_q       <= '0;
      end_q         <= '0;
      iter_q        <= '0;
      resv_q        <= '0;
      for (int k = 0; k < MAC_LAT; k++) tag_q[k] <= 4'd0;
      Opcode        <= 4'd0;
      Sel0          <= 2'd0;
      Sel1          <= 2'd0;
      Sel2          <= 2'd0;
      Issue_Valid   <= 1'b0;
      Result_Valid  <= 1'b0;
      Result_Opcode <= 4'd0;
      Done          <= 1'b0;
      Err           <= 1'b0;
    end else begin
      resv_q        <= resv_d;
      for (int k = 0; k < MAC_LAT; k++) tag_q[k] <= tag_d[k];
      Result_Valid  <= resv_q[0];
      Result_Opcode <= resv_q[0] ? tag_q[0] : 4'd0;
      Done          <= (state_q == S_DRAIN) && (resv_q == '0);
      Issue_Valid   <= do_issue;
      Opcode        <= (do_issue && !reserved) ? op : 4'd0;
      Sel0          <= (do_issue && !reserved) ? instr[5:4] : 2'd0;
      Sel1          <= (do_issue && !reserved) ? instr[7:6] : 2'd0;
      Sel2          <= (do_issue && !reserved) ? instr[9:8] : 2'd0;
      if (start_ok) begin
        pc_q    <= Start_Addr;
        start_q <= Start_Addr;
        end_q   <= End_Addr;
        iter_q  <= (Iter_Num == 16'd0) ? 16'd1 : Iter_Num;
        Err     <= 1'b0;
      end else if (do_issue) begin
        if (reserved) Err <= 1'b1;
        if (pc_q == end_q) begin
          pc_q   <= start_q;
          iter_q <= iter_q - 16'd1;
        end else begin
          pc_q <= pc_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched: expected issue/result/done events are queued
// with their edge index relative to Start, and monitors pop them as the DUT emits.
module tb_alu_issue_sched;

  logic       Clk = 1'b0;
  logic       Reset, Cfg_We, Start, Stall;
  logic [7:0] Cfg_Addr, Start_Addr, End_Addr;
  logic [9:0] Cfg_Data;
  logic [15:0] Iter_Num;
  logic [3:0] Opcode, Result_Opcode;
  logic [1:0] Sel0, Sel1, Sel2, Dbg_State;
  logic       Issue_Valid, Result_Valid, Busy, Done, Err;
  logic [7:0] Dbg_Pc;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int e0    = 0;

  logic [25:0] iss_q[$];
  logic [19:0] res_q[$];
  logic [15:0] done_q[$];

  alu_issue_sched #(.AWIDTH(8), .MAC_LAT(3), .ADDSUB_LAT(2)) dut (
    .Clk(Clk), .Reset(Reset), .Cfg_We(Cfg_We), .Cfg_Addr(Cfg_Addr), .Cfg_Data(Cfg_Data),
    .Start(Start), .Start_Addr(Start_Addr), .End_Addr(End_Addr), .Iter_Num(Iter_Num),
    .Stall(Stall), .Opcode(Opcode), .Sel0(Sel0), .Sel1(Sel1), .Sel2(Sel2),
    .Issue_Valid(Issue_Valid), .Result_Valid(Result_Valid), .Result_Opcode(Result_Opcode),
    .Busy(Busy), .Done(Done), .Err(Err), .Dbg_State(Dbg_State), .Dbg_Pc(Dbg_Pc)
  );

  // Clock / cycle counter
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Scoreboard helpers
  function automatic logic [9:0] ins(input logic [3:0] op, input logic [1:0] s0,
                                     input logic [1:0] s1, input logic [1:0] s2);
    return {s2, s1, s0, op};
  endfunction

  task automatic exp_issue(input int k, input logic [3:0] op, input logic [1:0] s0,
                           input logic [1:0] s1, input logic [1:0] s2);
    iss_q.push_back({16'(k), op, s2, s1, s0});
  endtask

  task automatic exp_res(input int k, input logic [3:0] op);
    res_q.push_back({16'(k), op});
  endtask

  task automatic exp_done(input int k);
    done_q.push_back(16'(k));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitors
  logic [25:0] iss_got, iss_exp;
  logic [19:0] res_got, res_exp;
  logic [15:0] done_got, done_exp;

  always @(negedge Clk) begin
    if (Issue_Valid) begin
      iss_got = {16'(cyc - e0), Opcode, Sel2, Sel1, Sel0};
      iss_exp = (iss_q.size() != 0) ? iss_q.pop_front() : 26'h3ffffff;
      check("issue {edge,op,s2,s1,s0}", 32'(iss_got), 32'(iss_exp));
    end
    if (Result_Valid) begin
      res_got = {16'(cyc - e0), Result_Opcode};
      res_exp = (res_q.size() != 0) ? res_q.pop_front() : 20'hfffff;
      check("result {edge,op}", 32'(res_got), 32'(res_exp));
    end
    if (Done) begin
      done_got = 16'(cyc - e0);
      done_exp = (done_q.size() != 0) ? done_q.pop_front() : 16'hffff;
      check("done edge", 32'(done_got), 32'(done_exp));
    end
  end

  // Driver tasks; each returns 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [9:0] d);
    Cfg_We = 1'b1; Cfg_Addr = a; Cfg_Data = d;
    tick(1);
    Cfg_We = 1'b0;
  endtask

  task automatic start_seq(input logic [7:0] s, input logic [7:0] e, input logic [15:0] it);
    Start = 1'b1; Start_Addr = s; End_Addr = e; Iter_Num = it;
    tick(1);
    Start = 1'b0;
    e0 = cyc;
  endtask

  task automatic finish_seq(input string name);
    int n = 0;
    while (Busy && n < 60) begin
      tick(1);
      n++;
    end
    check({name, " busy after budget"}, 32'(Busy), 32'd0);
    tick(4);
    check({name, " issue_q left"}, iss_q.size(), 0);
    check({name, " res_q left"}, res_q.size(), 0);
    check({name, " done_q left"}, done_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " Opcode"}, 32'(Opcode), 0);
    check({name, " Sels"}, 32'({Sel2, Sel1, Sel0}), 0);
    check({name, " Issue_Valid"}, 32'(Issue_Valid), 0);
    check({name, " Result_Valid"}, 32'(Result_Valid), 0);
    check({name, " Result_Opcode"}, 32'(Result_Opcode), 0);
    check({name, " Busy"}, 32'(Busy), 0);
    check({name, " Done"}, 32'(Done), 0);
    check({name, " Err"}, 32'(Err), 0);
  endtask

  logic [1:0] wrap_sel [4];

  initial begin
    Reset = 1'b1; Cfg_We = 1'b0; Start = 1'b0; Stall = 1'b0;
    Cfg_Addr = '0; Cfg_Data = '0; Start_Addr = '0; End_Addr = '0; Iter_Num = '0;
    tick(3);
    check_reset_outputs("reset");
    check("reset Dbg_Pc", 32'(Dbg_Pc), 0);
    Reset = 1'b0;
    tick(1);

    // ADDADD then PHI: PHI would collide with the ADD writeback and is bubbled once
    cfg_write(8'd0, ins(4'h3, 2'd3, 2'd2, 2'd1));
    cfg_write(8'd1, ins(4'h6, 2'd1, 2'd0, 2'd2));
    exp_issue(1, 4'h3, 2'd3, 2'd2, 2'd1);
    exp_issue(3, 4'h6, 2'd1, 2'd0, 2'd2);
    exp_res(3, 4'h3);
    exp_res(4, 4'h6);
    exp_done(5);
    start_seq(8'd0, 8'd1, 16'd1);
    check("busy after start", 32'(Busy), 1);
    finish_seq("addphi");

    // MULADD, GT, GT: second GT bubbled behind the MUL writeback
    cfg_write(8'd10, ins(4'h1, 2'd1, 2'd1, 2'd1));
    cfg_write(8'd11, ins(4'h7, 2'd2, 2'd0, 2'd0));
    cfg_write(8'd12, ins(4'h7, 2'd0, 2'd3, 2'd0));
    exp_issue(1, 4'h1, 2'd1, 2'd1, 2'd1);
    exp_issue(2, 4'h7, 2'd2, 2'd0, 2'd0);
    exp_issue(4, 4'h7, 2'd0, 2'd3, 2'd0);
    exp_res(3, 4'h7);
    exp_res(4, 4'h1);
    exp_res(5, 4'h7);
    exp_done(6);
    start_seq(8'd10, 8'd12, 16'd1);
    finish_seq("mulgt");

    // Wrapping range 254..1 for two iterations
    wrap_sel[0] = 2'd1; wrap_sel[1] = 2'd2; wrap_sel[2] = 2'd3; wrap_sel[3] = 2'd0;
    cfg_write(8'd254, ins(4'h6, 2'd1, 2'd0, 2'd0));
    cfg_write(8'd255, ins(4'h6, 2'd2, 2'd0, 2'd0));
    cfg_write(8'd0,   ins(4'h6, 2'd3, 2'd0, 2'd0));
    cfg_write(8'd1,   ins(4'h6, 2'd0, 2'd1, 2'd0));
    for (int it = 0; it < 2; it++) begin
      for (int j = 0; j < 4; j++) begin
        exp_issue(1 + it * 4 + j, 4'h6, wrap_sel[j], (j == 3) ? 2'd1 : 2'd0, 2'd0);
        exp_res(2 + it * 4 + j, 4'h6);
      end
    end
    exp_done(10);
    start_seq(8'd254, 8'd1, 16'd2);
    check("wrap pc after start", 32'(Dbg_Pc), 254);
    finish_seq("wrap");

    // Stall for three edges while a MULSUB is in flight
    cfg_write(8'd20, ins(4'h2, 2'd0, 2'd0, 2'd1));
    cfg_write(8'd21, ins(4'h8, 2'd1, 2'd1, 2'd0));
    cfg_write(8'd22, ins(4'h8, 2'd2, 2'd2, 2'd2));
    exp_issue(1, 4'h2, 2'd0, 2'd0, 2'd1);
    exp_issue(5, 4'h8, 2'd1, 2'd1, 2'd0);
    exp_issue(6, 4'h8, 2'd2, 2'd2, 2'd2);
    exp_res(4, 4'h2);
    exp_res(6, 4'h8);
    exp_res(7, 4'h8);
    exp_done(8);
    start_seq(8'd20, 8'd22, 16'd1);
    tick(1);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall pc frozen", 32'(Dbg_Pc), 21);
      check("stall no issue", 32'(Issue_Valid), 0);
    end
    Stall = 1'b0;
    finish_seq("stall");

    // Reserved opcode, NOP, then ADDSUB; Iter_Num=0 runs once
    cfg_write(8'd30, ins(4'hA, 2'd0, 2'd0, 2'd0));
    cfg_write(8'd31, ins(4'h0, 2'd0, 2'd0, 2'd0));
    cfg_write(8'd32, ins(4'h4, 2'd1, 2'd2, 2'd3));
    exp_issue(1, 4'h0, 2'd0, 2'd0, 2'd0);
    exp_issue(2, 4'h0, 2'd0, 2'd0, 2'd0);
    exp_issue(3, 4'h4, 2'd1, 2'd2, 2'd3);
    exp_res(5, 4'h4);
    exp_done(6);
    start_seq(8'd30, 8'd32, 16'd0);
    tick(1);
    check("reserved Err set", 32'(Err), 1);
    check("reserved Opcode", 32'(Opcode), 0);
    check("reserved Issue_Valid", 32'(Issue_Valid), 1);
    finish_seq("reserved");
    check("Err sticky in idle", 32'(Err), 1);

    // Reset two cycles after a MUL issue drops everything in flight
    cfg_write(8'd40, ins(4'h1, 2'd3, 2'd3, 2'd3));
    cfg_write(8'd41, ins(4'h6, 2'd0, 2'd2, 2'd0));
    exp_issue(1, 4'h1, 2'd3, 2'd3, 2'd3);
    exp_issue(2, 4'h6, 2'd0, 2'd2, 2'd0);
    start_seq(8'd40, 8'd41, 16'd1);
    check("Err cleared by Start", 32'(Err), 0);
    tick(2);
    Reset = 1'b1;
    tick(1);
    check_reset_outputs("midrun reset");
    Reset = 1'b0;
    tick(8);
    check("after reset issue_q", iss_q.size(), 0);
    Start = 1'b1; Reset = 1'b1; Start_Addr = 8'd40; End_Addr = 8'd41; Iter_Num = 16'd1;
    tick(1);
    Start = 1'b0; Reset = 1'b0;
    check("reset beats start", 32'(Busy), 0);
    tick(1);
    exp_issue(1, 4'h1, 2'd3, 2'd3, 2'd3);
    exp_issue(2, 4'h6, 2'd0, 2'd2, 2'd0);
    exp_res(3, 4'h6);
    exp_res(4, 4'h1);
    exp_done(5);
    start_seq(8'd40, 8'd41, 16'd1);
    finish_seq("post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
